// File: rtl/cfg_pkg.sv
// Shared types and default sizes for the serial configuration chain loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } cfg_state_t;

  localparam int CFG_WORD_W   = 8;
  localparam int LEI_CFG_BITS = 48;

endpackage

// File: rtl/cfg_serdes_bit.sv
// One-word PISO/SIPO pair: the transmit register feeds the chain head MSB-first,
// the receive register collects bits from the chain tail into the LSB.
module cfg_serdes_bit
  import cfg_pkg::*;
#(
  parameter int WORD_W = CFG_WORD_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              clr,
  input  logic              sin,
  output logic              sout,
  output logic [WORD_W-1:0] rx_word
);

  logic [WORD_W-1:0] tx_buf;
  // Only WORD_W-1 bits need storing: the newest bit comes straight from sin.
  logic [WORD_W-2:0] rx_buf;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_buf <= '0;
      rx_buf <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (load)       tx_buf <= load_data;
      else if (shift) tx_buf <= {tx_buf[WORD_W-2:0], 1'b0};

      if (clr)        rx_buf <= '0;
      else if (shift) rx_buf <= rx_word[WORD_W-2:0];
    end
  end

  assign sout    = tx_buf[WORD_W-1];
  assign rx_word = {rx_buf, sin};

endmodule

// File: rtl/cfg_chain_loader.sv
// Master end of the config chain: serialises written words into the chain head
// and returns the bits falling out of the tail as readback words.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int WORD_W    = CFG_WORD_W,
  parameter int CHAIN_LEN = LEI_CFG_BITS
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              cfg_en,
  output logic              cfg_shift,
  output logic              cfg_din,
  input  logic              cfg_dout,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS = CHAIN_LEN / WORD_W;
  localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int WRD_W  = $clog2(NWORDS + 1);

  if (CHAIN_LEN % WORD_W != 0) begin : g_len_chk
    $error("cfg_chain_loader: CHAIN_LEN must be a multiple of WORD_W");
  end

  cfg_state_t        state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  rx_cnt;
  logic [WRD_W-1:0]  words_in;
  logic [WORD_W-1:0] rx_word;
  logic              shift_now;
  logic              wr_fire;
  logic              rd_fire;
  logic              rx_full;
  logic              start_fire;

  // A readback word the consumer has not taken freezes the whole chain.
  assign shift_now  = (state == LOAD) && (tx_cnt != '0) && !(rd_valid && !rd_ready);
  assign wr_ready   = (state == LOAD) && (words_in < WRD_W'(NWORDS)) &&
                      ((tx_cnt == '0) || ((tx_cnt == CNT_W'(1)) && shift_now));
  assign wr_fire    = wr_valid && wr_ready;
  assign rd_fire    = rd_valid && rd_ready;
  assign rx_full    = shift_now && (rx_cnt == CNT_W'(WORD_W - 1));
  assign start_fire = (state == IDLE) && start;
  assign cfg_shift  = shift_now;
  assign done       = (state == FLUSH) && rd_fire;

  cfg_serdes_bit #(.WORD_W(WORD_W)) u_serdes (
    .clk      (clk),
    .nrst     (nrst),
    .load     (wr_fire),
    .load_data(wr_data),
    .shift    (shift_now),
    .clr      (start_fire),
    .sin      (cfg_dout),
    .sout     (cfg_din),
    .rx_word  (rx_word)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      words_in <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      cfg_en   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            cfg_en   <= 1'b1;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            words_in <= '0;
          end
        end
        LOAD: begin
          // A word accepted on its predecessor's last bit refills without a gap.
          if (wr_fire) begin
            tx_cnt   <= CNT_W'(WORD_W);
            words_in <= words_in + 1'b1;
          end else if (shift_now) begin
            tx_cnt   <= tx_cnt - 1'b1;
          end
          if (shift_now) begin
            bit_cnt <= bit_cnt + 1'b1;
            rx_cnt  <= rx_full ? '0 : rx_cnt + 1'b1;
            if (bit_cnt == BIT_W'(CHAIN_LEN - 1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (rd_fire) begin
            state  <= IDLE;
            cfg_en <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (rx_full) begin
        rd_data  <= rx_word;
        rd_valid <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Randomised bench for cfg_chain_loader: a behavioural 48-bit chain sits on the
// serial pins; a scoreboard predicts readback words and final chain contents.
module tb_cfg_chain_loader;
  import cfg_pkg::*;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 48;
  localparam int NWORDS    = CHAIN_LEN / WORD_W;
  localparam logic [CHAIN_LEN-1:0] CHAIN_INIT = 48'h1234_5678_9ABC;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              start = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              cfg_en, cfg_shift, cfg_din, cfg_dout, busy, done;

  always #5 clk = ~clk;

  cfg_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .clk(clk), .nrst(nrst), .start(start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .cfg_en(cfg_en), .cfg_shift(cfg_shift), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .busy(busy), .done(done)
  );

  // Behavioural config chain: head at bit 0, tail at the top bit.
  logic [CHAIN_LEN-1:0] chain = CHAIN_INIT;
  always @(posedge clk) if (cfg_shift) chain <= {chain[CHAIN_LEN-2:0], cfg_din};
  assign cfg_dout = chain[CHAIN_LEN-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WORD_W-1:0] data;
    bit                care;
  } rd_exp_t;

  rd_exp_t           rd_q[$];
  logic [WORD_W-1:0] model_words[NWORDS];
  bit                model_known;
  logic [WORD_W-1:0] tx_words[NWORDS];
  int                rd_mode = 0;

  // Monitor: counts shifts/runs/done pulses and scores every readback handshake.
  int   shift_total = 0, run_total = 0, done_total = 0, stall_snap = 0;
  logic prev_shift = 1'b0, prev_done = 1'b0, prev_stall = 1'b0;

  always @(negedge clk) begin
    if (nrst) begin
      if (cfg_shift) begin
        shift_total <= shift_total + 1;
        if (!prev_shift) run_total <= run_total + 1;
      end
      if (rd_valid && !rd_ready) begin
        check("stall_no_shift", 64'(cfg_shift), 64'd0);
        if (!prev_stall) stall_snap <= shift_total;
      end
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got word %0h with none expected", rd_data);
        end else begin
          if (rd_q[0].care) check("readback", 64'(rd_data), 64'(rd_q[0].data));
          rd_q.delete(0);
        end
      end
      if (done) begin
        done_total <= done_total + 1;
        check("cfg_en_at_done", 64'(cfg_en), 64'd1);
      end
      if (prev_done) check("cfg_en_after_done", 64'(cfg_en), 64'd0);
      prev_shift <= cfg_shift;
      prev_done  <= done;
      prev_stall <= rd_valid && !rd_ready;
    end else begin
      prev_shift <= 1'b0;
      prev_done  <= 1'b0;
      prev_stall <= 1'b0;
    end
  end

  // Readback consumer: 0 = always ready, 1 = random, 2 = hold off the first word.
  initial begin
    int stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        1: rd_ready = 1'($urandom_range(0, 1));
        2: begin
          if (rd_valid && !rd_ready) stall_cnt++;
          rd_ready = (stall_cnt >= 6);
        end
        default: rd_ready = 1'b1;
      endcase
      if (rd_mode != 2) stall_cnt = 0;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_ready"}, 64'(wr_ready), 64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    check({tag, "_cfg_en"}, 64'(cfg_en), 64'd0);
    check({tag, "_cfg_shift"}, 64'(cfg_shift), 64'd0);
    check({tag, "_cfg_din"}, 64'(cfg_din), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic random_words();
    for (int i = 0; i < NWORDS; i++) tx_words[i] = WORD_W'($urandom);
  endtask

  // One complete load; exp_runs < 0 skips the contiguous-shift check.
  task automatic do_load(input int gap, input int mode, input bit restart_mid, input int exp_runs);
    int sb, rb, db, t;
    bit hs;
    logic [CHAIN_LEN-1:0] exp_chain;
    for (int i = 0; i < NWORDS; i++) rd_q.push_back('{model_words[i], model_known});
    rd_mode = mode;
    sb = shift_total;
    rb = run_total;
    db = done_total;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("cfg_en_rise", 64'(cfg_en), 64'd1);
    check("busy_rise", 64'(busy), 64'd1);
    for (int i = 0; i < NWORDS; i++) begin
      if (gap > 0) begin
        wr_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      wr_valid = 1'b1;
      wr_data  = tx_words[i];
      if (restart_mid && i == 2) start = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        hs = wr_ready;
        @(posedge clk); #1;
        start = 1'b0;
        t++;
      end while (!hs && t < 300);
      if (!hs) check("wr_handshake_timeout", 64'(t), 64'd0);
    end
    wr_valid = 1'b0;
    t = 0;
    while (done_total == db && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (done_total == db) check("done_timeout", 64'(t), 64'd0);
    repeat (4) @(negedge clk);
    exp_chain = '0;
    for (int i = 0; i < NWORDS; i++) exp_chain = {exp_chain[CHAIN_LEN-WORD_W-1:0], tx_words[i]};
    check("done_once", 64'(done_total - db), 64'd1);
    check("shift_count", 64'(shift_total - sb), 64'(CHAIN_LEN));
    if (exp_runs >= 0) check("shift_runs", 64'(run_total - rb), 64'(exp_runs));
    if (mode == 2) check("stall_at_bit", 64'(stall_snap - sb), 64'(WORD_W));
    check("chain_contents", 64'(chain), 64'(exp_chain));
    check("readback_drained", 64'(rd_q.size()), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_cfg_en", 64'(cfg_en), 64'd0);
    for (int i = 0; i < NWORDS; i++) model_words[i] = tx_words[i];
    model_known = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb, db, t;
    for (int i = 0; i < NWORDS; i++) model_words[i] = CHAIN_INIT[CHAIN_LEN-1-WORD_W*i -: WORD_W];
    model_known = 1'b1;

    // Reset with start held: everything stays at reset values.
    #2 nrst = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 start = 1'b0;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("start_in_reset_ignored", 64'(cfg_en), 64'd0);

    // Word source active in IDLE is never accepted.
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check("idle_wr_ready", 64'(wr_ready), 64'd0);
    end
    @(posedge clk); #1 wr_valid = 1'b0;

    tx_words = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h7E};
    do_load(0, 0, 1'b0, 1);

    // Reset while idle clears the held readback word.
    @(posedge clk); #1 nrst = 1'b0;
    @(negedge clk);
    check_outputs_zero("idle_reset");
    @(posedge clk); #1 nrst = 1'b1;

    tx_words = '{default: 8'h00};
    do_load(0, 0, 1'b0, 1);

    random_words();
    do_load(0, 2, 1'b0, 2);

    random_words();
    do_load(0, 0, 1'b1, 1);

    random_words();
    do_load(WORD_W + 5, 0, 1'b0, NWORDS);

    // Reset after about 20 shifts: outputs drop at once, chain becomes unknown.
    for (int i = 0; i < NWORDS; i++) rd_q.push_back('{8'h00, 1'b0});
    rd_mode = 0;
    sb = shift_total;
    db = done_total;
    wr_data  = 8'hC3;
    wr_valid = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (shift_total - sb < 20 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (shift_total - sb < 20) check("midload_timeout", 64'(t), 64'd0);
    nrst = 1'b0;
    #1;
    check("midload_cfg_en", 64'(cfg_en), 64'd0);
    check("midload_busy", 64'(busy), 64'd0);
    check("midload_cfg_shift", 64'(cfg_shift), 64'd0);
    check("midload_no_done", 64'(done_total - db), 64'd0);
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    rd_q.delete();
    model_known = 1'b0;

    random_words();
    do_load(0, 0, 1'b0, 1);

    for (int n = 0; n < 4; n++) begin
      random_words();
      do_load($urandom_range(0, 2), 1, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
